driver_rx_model: RTL
====================

# driver_rx_model

Receiving end of the LED-driver serial link: a single-lane decoder that watches the SCLK/LAT/SIN/GCLK pins the FPGA drives into one driver and recovers the latch commands, grayscale words and configuration word exactly as the driver would. It oversamples the pins with one fast clock and emits decoded events. It is used as the golden checker in controller benches and as an on-FPGA loopback monitor on a spare lane.

## Interface
Parameters:
- `GROUPS`, 16: number of GS words per segment; the group index wraps modulo `GROUPS`.
- `WORD_BITS`, 48: width of the shift register and of the GS/FC words.

Ports:
- `clk_hse` in, 1: sampling clock. Each SCLK/GCLK high and low phase must last ≥2 `clk_hse` periods.
- `nrst` in, 1: asynchronous, active-low reset.
- `driver_sclk`, `driver_lat`, `driver_sin`, `driver_gclk` in, 1 each: raw driver pins, asynchronous to `clk_hse`.
- `gs_wr` out, 1: one-cycle pulse; a GS word was written.
- `gs_group` out, 4: group index of that write.
- `gs_data` out, `WORD_BITS`: the word written.
- `latgs` out, 1: one-cycle pulse on a LATGS or LINERESET command.
- `line_reset` out, 1: one-cycle pulse on a LINERESET command.
- `segment_gclk` out, 10: GCLK rising edges since the previous LATGS/LINERESET. Saturates at 1023 and is valid with `latgs`.
- `fc_valid` out, 1: one-cycle pulse when an accepted WRTFC loads `fc_data`.
- `fc_data` out, `WORD_BITS`: last accepted configuration word. Holds its value between loads.
- `fc_wr_en` out, 1: level; FC write is armed.
- `readfc` out, 1: one-cycle pulse on a READFC command.
- `cmd_err` out, 1: one-cycle pulse on an unknown edge count, or on WRTFC while not armed.
- `word_len` out, 8: SCLK edges since the previous command (0 after reset). Saturates at 255 and updates on every decoded command.

## Operation
Input conditioning:
- Each pin passes through a 2-flop synchronizer followed by a history flop.
- An edge is detected when the synchronized value differs from its history flop.

On each SCLK rising edge:
- Shift the bit in, MSB first: `shreg <= {shreg[WORD_BITS-2:0], sin}`.
- `bit_cnt++`, saturating at 255.
- If synchronized LAT is high, `lat_cnt++`, saturating at 31.

On each GCLK rising edge: `gclk_cnt++`, saturating at 1023.

On a LAT falling edge, decode `lat_cnt`:
- 1 WRTGS: `gs_wr`; `gs_data=shreg`; `gs_group=grp`; `grp <= (grp+1) mod GROUPS`.
- 3 LATGS: same GS write as WRTGS, then `latgs`; `segment_gclk=gclk_cnt`; `grp<=0`; `gclk_cnt<=0`.
- 7 LINERESET: same as LATGS, plus `line_reset`.
- 15 FCWRTEN: `fc_wr_en<=1`.
- 5 WRTFC: if `fc_wr_en`, then `fc_data<=shreg`, `fc_valid`, `fc_wr_en<=0`. If not armed, `cmd_err` and `fc_data` is unchanged.
- 11 READFC: `readfc`. `fc_wr_en` is unchanged.
- 0 edges: no command, no pulse; `word_len` is not updated.
- Any other count: `cmd_err`.
- Every decode except the 0-edge case loads `word_len<=bit_cnt` and clears `bit_cnt`.
- Every LAT fall, including the 0-edge case, clears `lat_cnt`.

Simultaneous events:
- An SCLK rise in the same cycle as a LAT fall is processed first: its bit is shifted in, it counts as a LAT-high edge, and decode uses the updated values.
- A GCLK rise in the same cycle as a LATGS decode is counted into the reported `segment_gclk`, then the counter clears.

Reset: all outputs, counters, `grp` and `shreg` go to 0. `fc_data` resets to 0. Reset mid-command discards the partial command.

## Timing
- Pulse outputs are registered. They assert for exactly one `clk_hse` cycle, beginning on the 3rd `clk_hse` rising edge after the edge that first samples LAT low.
- `gs_data`, `gs_group`, `word_len` and `segment_gclk` are stable during their pulse and hold until the next update.
- `fc_wr_en` changes in the same cycle as the decode pulse timing.
- There is no backpressure; a consumer must accept every pulse.
- Maximum command rate is one per LAT low/high pair. Each LAT phase must last ≥2 `clk_hse` cycles.

## Test plan
- FCWRTEN: 15 SCLK rises with LAT high, then LAT falls. Next, WRTFC: 48 bits of `0xA5A5_1234_5678`, LAT high for the last 5 → `fc_wr_en` 1 then 0; `fc_valid` pulses once; `fc_data=0xA5A5_1234_5678`; `word_len=48`.
- WRTFC without a prior FCWRTEN → `cmd_err` pulses once; `fc_data` unchanged; no `fc_valid`.
- Segment of 8 WRTGS words 0x1..0x8, then LATGS (3 edges) with 512 GCLK rises → `gs_wr` ×9 with groups 0..8; `latgs` pulses once; `segment_gclk=512`; next WRTGS uses group 0.
- 17 WRTGS with no LATGS → groups run 0..15 then 0; LINERESET (7 edges) → `latgs` and `line_reset` both pulse.
- LAT high for 4 SCLK edges → `cmd_err`; 0-edge LAT pulse → no outputs, `word_len` unchanged; SCLK rise coincident with LAT fall on 2 edges → decoded as LATGS.
- Assert `nrst` low while `lat_cnt=10` and mid-word → all outputs 0; after release, a clean WRTGS decodes with group 0.

Source files
------------

// File: rtl/driver_rx_model.sv
// driver_rx_model: oversampling decoder for one LED-driver serial lane.
// Recovers GS/FC writes and latch commands from the raw SCLK/LAT/SIN/GCLK pins.
module driver_rx_model #(
  parameter int GROUPS    = 16,
  parameter int WORD_BITS = 48
) (
  input  logic                 clk_hse,
  input  logic                 nrst,
  input  logic                 driver_sclk,
  input  logic                 driver_lat,
  input  logic                 driver_sin,
  input  logic                 driver_gclk,
  output logic                 gs_wr,
  output logic [3:0]           gs_group,
  output logic [WORD_BITS-1:0] gs_data,
  output logic                 latgs,
  output logic                 line_reset,
  output logic [9:0]           segment_gclk,
  output logic                 fc_valid,
  output logic [WORD_BITS-1:0] fc_data,
  output logic                 fc_wr_en,
  output logic                 readfc,
  output logic                 cmd_err,
  output logic [7:0]           word_len
);

  localparam int PIN_SCLK = 0;
  localparam int PIN_LAT  = 1;
  localparam int PIN_SIN  = 2;
  localparam int PIN_GCLK = 3;

  localparam logic [4:0] CMD_NONE   = 5'd0;
  localparam logic [4:0] CMD_WRTGS  = 5'd1;
  localparam logic [4:0] CMD_LATGS  = 5'd3;
  localparam logic [4:0] CMD_WRTFC  = 5'd5;
  localparam logic [4:0] CMD_LINE   = 5'd7;
  localparam logic [4:0] CMD_READFC = 5'd11;
  localparam logic [4:0] CMD_FCWEN  = 5'd15;

  logic [3:0] pin_raw;
  logic [3:0] sync_val;
  logic [3:0] hist_val;

  assign pin_raw = {driver_gclk, driver_sin, driver_lat, driver_sclk};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sync
    logic s1_reg, s2_reg, h_reg;
    always_ff @(posedge clk_hse or negedge nrst) begin
      if (!nrst) begin
        s1_reg <= 1'b0;
        s2_reg <= 1'b0;
        h_reg  <= 1'b0;
      end else begin
        s1_reg <= pin_raw[gi];
        s2_reg <= s1_reg;
        h_reg  <= s2_reg;
      end
    end
    assign sync_val[gi] = s2_reg;
    assign hist_val[gi] = h_reg;
  end

  // Edge flags are registered once more so decode lands on the 3rd edge after LAT is first sampled low.
  logic sclk_rise_reg, lat_fall_reg, lat_high_reg, sin_reg, gclk_rise_reg;

  always_ff @(posedge clk_hse or negedge nrst) begin
    if (!nrst) begin
      sclk_rise_reg <= 1'b0;
      lat_fall_reg  <= 1'b0;
      lat_high_reg  <= 1'b0;
      sin_reg       <= 1'b0;
      gclk_rise_reg <= 1'b0;
    end else begin
      sclk_rise_reg <= sync_val[PIN_SCLK] & ~hist_val[PIN_SCLK];
      lat_fall_reg  <= ~sync_val[PIN_LAT] & hist_val[PIN_LAT];
      // LAT level just before this sample, so a coincident LAT fall still counts as high
      lat_high_reg  <= hist_val[PIN_LAT];
      sin_reg       <= sync_val[PIN_SIN];
      gclk_rise_reg <= sync_val[PIN_GCLK] & ~hist_val[PIN_GCLK];
    end
  end

  logic [WORD_BITS-1:0] shreg_reg, shreg_next;
  logic [7:0]           bit_cnt_reg, bit_cnt_next;
  logic [4:0]           lat_cnt_reg, lat_cnt_next;
  logic [9:0]           gclk_cnt_reg, gclk_cnt_next;
  logic [3:0]           grp_reg, grp_next;
  logic                 fc_wr_en_reg, fc_wr_en_next;
  logic [WORD_BITS-1:0] fc_data_reg, fc_data_next;
  logic [WORD_BITS-1:0] gs_data_reg, gs_data_next;
  logic [3:0]           gs_group_reg, gs_group_next;
  logic [7:0]           word_len_reg, word_len_next;
  logic [9:0]           segment_gclk_reg, segment_gclk_next;
  logic                 gs_wr_reg, gs_wr_next;
  logic                 latgs_reg, latgs_next;
  logic                 line_reset_reg, line_reset_next;
  logic                 fc_valid_reg, fc_valid_next;
  logic                 readfc_reg, readfc_next;
  logic                 cmd_err_reg, cmd_err_next;
  logic [4:0]           cmd_code;

  always_comb begin
    shreg_next        = shreg_reg;
    bit_cnt_next      = bit_cnt_reg;
    lat_cnt_next      = lat_cnt_reg;
    gclk_cnt_next     = gclk_cnt_reg;
    grp_next          = grp_reg;
    fc_wr_en_next     = fc_wr_en_reg;
    fc_data_next      = fc_data_reg;
    gs_data_next      = gs_data_reg;
    gs_group_next     = gs_group_reg;
    word_len_next     = word_len_reg;
    segment_gclk_next = segment_gclk_reg;
    gs_wr_next        = 1'b0;
    latgs_next        = 1'b0;
    line_reset_next   = 1'b0;
    fc_valid_next     = 1'b0;
    readfc_next       = 1'b0;
    cmd_err_next      = 1'b0;
    cmd_code          = CMD_NONE;

    if (sclk_rise_reg) begin
      shreg_next = {shreg_reg[WORD_BITS-2:0], sin_reg};
      if (bit_cnt_reg != 8'd255) bit_cnt_next = bit_cnt_reg + 8'd1;
      if (lat_high_reg && lat_cnt_reg != 5'd31) lat_cnt_next = lat_cnt_reg + 5'd1;
    end
    if (gclk_rise_reg && gclk_cnt_reg != 10'd1023) gclk_cnt_next = gclk_cnt_reg + 10'd1;

    // Decode sees the counters already updated by any same-cycle SCLK/GCLK edge.
    if (lat_fall_reg) begin
      cmd_code     = lat_cnt_next;
      lat_cnt_next = 5'd0;
      if (cmd_code != CMD_NONE) begin
        word_len_next = bit_cnt_next;
        bit_cnt_next  = 8'd0;
      end
      case (cmd_code)
        CMD_WRTGS, CMD_LATGS, CMD_LINE: begin
          gs_wr_next    = 1'b1;
          gs_data_next  = shreg_next;
          gs_group_next = grp_reg;
          grp_next      = (grp_reg == 4'(GROUPS - 1)) ? 4'd0 : grp_reg + 4'd1;
          if (cmd_code != CMD_WRTGS) begin
            latgs_next        = 1'b1;
            line_reset_next   = (cmd_code == CMD_LINE);
            segment_gclk_next = gclk_cnt_next;
            grp_next          = 4'd0;
            gclk_cnt_next     = 10'd0;
          end
        end
        CMD_FCWEN: fc_wr_en_next = 1'b1;
        CMD_WRTFC: begin
          if (fc_wr_en_reg) begin
            fc_data_next  = shreg_next;
            fc_valid_next = 1'b1;
            fc_wr_en_next = 1'b0;
          end else begin
            cmd_err_next = 1'b1;
          end
        end
        CMD_READFC: readfc_next = 1'b1;
        CMD_NONE:   ;
        default:    cmd_err_next = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_hse or negedge nrst) begin
    if (!nrst) begin
      shreg_reg        <= '0;
      bit_cnt_reg      <= '0;
      lat_cnt_reg      <= '0;
      gclk_cnt_reg     <= '0;
      grp_reg          <= '0;
      fc_wr_en_reg     <= 1'b0;
      fc_data_reg      <= '0;
      gs_data_reg      <= '0;
      gs_group_reg     <= '0;
      word_len_reg     <= '0;
      segment_gclk_reg <= '0;
      gs_wr_reg        <= 1'b0;
      latgs_reg        <= 1'b0;
      line_reset_reg   <= 1'b0;
      fc_valid_reg     <= 1'b0;
      readfc_reg       <= 1'b0;
      cmd_err_reg      <= 1'b0;
    end else begin
      shreg_reg        <= shreg_next;
      bit_cnt_reg      <= bit_cnt_next;
      lat_cnt_reg      <= lat_cnt_next;
      gclk_cnt_reg     <= gclk_cnt_next;
      grp_reg          <= grp_next;
      fc_wr_en_reg     <= fc_wr_en_next;
      fc_data_reg      <= fc_data_next;
      gs_data_reg      <= gs_data_next;
      gs_group_reg     <= gs_group_next;
      word_len_reg     <= word_len_next;
      segment_gclk_reg <= segment_gclk_next;
      gs_wr_reg        <= gs_wr_next;
      latgs_reg        <= latgs_next;
      line_reset_reg   <= line_reset_next;
      fc_valid_reg     <= fc_valid_next;
      readfc_reg       <= readfc_next;
      cmd_err_reg      <= cmd_err_next;
    end
  end

  assign gs_wr        = gs_wr_reg;
  assign gs_group     = gs_group_reg;
  assign gs_data      = gs_data_reg;
  assign latgs        = latgs_reg;
  assign line_reset   = line_reset_reg;
  assign segment_gclk = segment_gclk_reg;
  assign fc_valid     = fc_valid_reg;
  assign fc_data      = fc_data_reg;
  assign fc_wr_en     = fc_wr_en_reg;
  assign readfc       = readfc_reg;
  assign cmd_err      = cmd_err_reg;
  assign word_len     = word_len_reg;

endmodule
